fpu_add_result_collector: RTL

//   Downstream stage of the single-precision FP adder. Pairs each adder result with the

---
 rtl/fpu_add_result_collector_if.sv | 33 +++
 rtl/fpu_add_result_collector.sv | 108 ++++++++++
 2 files changed

// File: rtl/fpu_add_result_collector_if.sv
// Signal bundle between issue/adder, the FP add result collector and FP writeback.
interface fpu_add_result_collector_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             issue_req;
    logic [TAG_W-1:0] issue_rd;
    logic             add_valid;
    logic [31:0]      add_result;
    logic [2:0]       add_exc;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_rd;
    logic [31:0]      wb_data;
    logic [4:0]       wb_fflags;
    logic             fflags_clr;
    logic [4:0]       fflags_acc;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             overflow_err;

    modport master (
        output issue_req, issue_rd, add_valid, add_result, add_exc, wb_ready, fflags_clr,
        input  wb_valid, wb_rd, wb_data, wb_fflags, fflags_acc, count, full, overflow_err
    );

    modport slave (
        input  issue_req, issue_rd, add_valid, add_result, add_exc, wb_ready, fflags_clr,
        output wb_valid, wb_rd, wb_data, wb_fflags, fflags_acc, count, full, overflow_err
    );
endinterface

// File: rtl/fpu_add_result_collector.sv
// Pairs FP adder results with issue tags, maps exceptions to fflags and queues them for writeback.
// Optional: define FPU_RES_CANON_NAN_EN to canonicalize NaN results at push.
module fpu_add_result_collector #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned ADD_LAT = 1
) (
    input logic                      clk,
    input logic                      rst,
    fpu_add_result_collector_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0] rd;
        logic [31:0]      data;
        logic [4:0]       flags;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [TAG_W-1:0] tag_pipe [ADD_LAT];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       acc;
    logic             ovf;
    logic             is_empty;
    logic             is_full;
    logic             push;
    logic             pop;
    logic [4:0]       exc_flags;
    entry_t           new_entry;
    entry_t           head;

    // Idle slots shift in zero so a stale tag never lingers in the delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ADD_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= bus.issue_req ? bus.issue_rd : '0;
            for (int unsigned i = 1; i < ADD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    always_comb begin
        exc_flags = 5'b00000;
        case (bus.add_exc)
            3'b111:  exc_flags = 5'b00000;
            3'b100:  exc_flags = 5'b10000;
            3'b011:  exc_flags = 5'b01000;
            3'b010:  exc_flags = 5'b00101;
            3'b001:  exc_flags = 5'b00011;
            3'b000:  exc_flags = 5'b00001;
            default: exc_flags = 5'b10000;
        endcase
    end

    always_comb begin
        new_entry.rd    = tag_pipe[ADD_LAT-1];
        new_entry.data  = bus.add_result;
        new_entry.flags = exc_flags;
`ifdef FPU_RES_CANON_NAN_EN
        if (bus.add_result[30:23] == 8'hFF && bus.add_result[22:0] != '0) begin
            new_entry.data = 32'h7FC0_0000;
            if (bus.add_result != 32'h7FC0_0000) new_entry.flags[4] = 1'b1;
        end
`endif
    end

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);
    assign pop      = bus.wb_ready && !is_empty;
    assign push     = bus.add_valid && (!is_full || pop);
    assign head     = mem[rd_ptr];

    // A valid result that cannot be pushed is exactly the full-without-pop drop case.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            acc    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
            if (bus.add_valid && !push) ovf <= 1'b1;
            acc <= (bus.fflags_clr ? 5'b00000 : acc) | (pop ? head.flags : 5'b00000);
        end
    end

    assign bus.wb_valid     = !is_empty;
    assign bus.wb_rd        = head.rd;
    assign bus.wb_data      = head.data;
    assign bus.wb_fflags    = head.flags;
    assign bus.fflags_acc   = acc;
    assign bus.count        = cnt;
    assign bus.full         = is_full;
    assign bus.overflow_err = ovf;
endmodule
